bcd_display_driver: RTL and testbench
=====================================

BCD_DISPLAY_DRIVER -- requirements
Module: bcd_display_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: clock cycles per digit scan slot, legal range 2..2^20.
REQ-002 SHALL have parameter BLANK_LEADING, default 1: when 1, leading zeros are blanked.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port value_wr, input, 1 bit: single-cycle strobe requesting display of value_in.
REQ-006 SHALL have port value_in, input, 12 bits: unsigned binary value, sampled when value_wr=1.
REQ-007 SHALL have port seg_n, output, 7 bits: active-low segments, order {g,f,e,d,c,b,a}.
REQ-008 SHALL have port dig_sel_n, output, 3 bits: active-low one-hot digit enable; bit0 is the units digit.
REQ-009 SHALL have port status, output, 2 bits: {overflow, busy}; this feeds the 2-bit status PIO in_port directly.

Function
REQ-010 SHALL implement FSM IDLE -> SHIFT -> LATCH -> IDLE.
REQ-011 In IDLE, value_wr=1 SHALL load value_in into the shift register, clear the BCD accumulator and move to SHIFT.
REQ-012 SHIFT SHALL run a double-dabble conversion: add 3 to every BCD nibble >=5, then shift left 1, once per cycle, for exactly 12 cycles, then go to LATCH.
REQ-013 LATCH SHALL copy the 3 BCD nibbles into the display digit registers, set overflow=(sampled value >999), and return to IDLE; it lasts 1 cycle.
REQ-014 For value_wr at cycle N: busy=1 for cycles N+1..N+13; digits and overflow SHALL update at N+14, with busy=0 at N+14.
REQ-015 value_wr while not IDLE SHALL be ignored, with no effect on the conversion in flight.
REQ-016 value_wr in the same cycle the FSM returns to IDLE (the LATCH cycle) SHALL be ignored; it is accepted only when the FSM is in IDLE.
REQ-017 The BCD accumulator SHALL be 16 bits (4 nibbles) so that inputs up to 4095 convert without loss; only the low 3 nibbles are displayed.
REQ-018 When overflow=1, all three digits SHALL show a dash (seg_n=7'b0111111).
REQ-019 Overflow SHALL remain set until a later conversion of a value <=999 completes.
REQ-020 The scan prescaler SHALL count 0..SCAN_DIV-1; at terminal count the digit index SHALL advance 0->1->2->0.
REQ-021 seg_n and dig_sel_n SHALL both be registered and SHALL change in the same cycle, never showing a mismatched digit/segment pair.
REQ-022 With BLANK_LEADING=1, digit2 SHALL be blank (7'b1111111) if 0, and digit1 blank if digit2 is blank and digit1 is 0.
REQ-023 Digit0 SHALL never be blanked, and blanking SHALL never apply during overflow.
REQ-024 Segment codes SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-025 status SHALL be driven from registers, with no combinational path from any input.

Reset
REQ-026 On reset: FSM=IDLE, status=2'b00, digit registers=0, prescaler=0, digit index=0.
REQ-027 The first cycle after reset SHALL show dig_sel_n=3'b110 and seg_n=7'b1000000.
REQ-028 Reset during SHIFT or LATCH SHALL abort the conversion with no digit update.
REQ-029 Reset SHALL override a simultaneous value_wr.

Structure
REQ-030 Package bcd_pkg SHALL hold the FSM state enum, the segment pattern constants (digits, DASH, BLANK), NUM_DIGITS=3 and the iteration count 12.
REQ-031 Sub-module bcd_seg_decoder (4-bit nibble plus blank and dash flags -> 7-bit seg_n, combinational) SHALL be instantiated once, on the muxed digit.

Verification (bench uses SCAN_DIV=4)
REQ-032 Write 123 at cycle N -> status=01 for N+1..N+13, status=00 at N+14; scan shows seg 1111001/0100100/0110000 on dig_sel_n 011/101/110.
REQ-033 Write 7 -> digit2 and digit1 seg_n=1111111, digit0 seg_n=1111000; repeat with BLANK_LEADING=0 -> digits 2 and 1 show 1000000.
REQ-034 Write 1000 -> status=10 at N+14, all digits 0111111; then write 999 -> status=00, all digits 0010000.
REQ-035 Write 45 then write 999 at N+5 -> 999 ignored, display 45 at N+14; write 999 at N+13 -> ignored; write 999 at N+14 -> accepted.
REQ-036 Assert reset at N+6 of a 500 conversion -> status=00, display 0, dig_sel_n=110 on the next cycle; subsequent writes convert normally.
REQ-037 Scan timing: dig_sel_n SHALL advance every 4 cycles in the sequence 110->101->011->110, with seg_n changing in the same cycle as dig_sel_n.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD display driver: FSM states,
// segment patterns and the double-dabble helpers.
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_LATCH = 2'b10
  } state_t;

  localparam int NUM_DIGITS = 3;
  localparam int NUM_ITER   = 12;
  localparam int IN_W       = 12;
  localparam int ACC_W      = 16;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_code(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

  // Double-dabble correction: every nibble >= 5 gets 3 added before the shift
  function automatic logic [ACC_W-1:0] dd_adjust(input logic [ACC_W-1:0] acc);
    logic [ACC_W-1:0] res;
    res = acc;
    for (int i = 0; i < ACC_W / 4; i++) begin
      if (acc[4*i +: 4] >= 4'd5) begin
        res[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end else begin
        res[4*i +: 4] = acc[4*i +: 4];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bcd_seg_decoder.sv
// Nibble to active-low 7-segment decoder with dash and blank overrides.
module bcd_seg_decoder
  import bcd_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg_n
);

  // Dash wins over blank so an overflow display is never blanked
  always_comb begin
    seg_n = SEG_BLANK;
    if (dash) begin
      seg_n = SEG_DASH;
    end else if (blank) begin
      seg_n = SEG_BLANK;
    end else begin
      seg_n = seg_code(nibble);
    end
  end

endmodule

// File: rtl/bcd_display_driver.sv
// Binary-to-BCD converter (double dabble) driving a 3-digit multiplexed
// active-low 7-segment display, with overflow dashes and leading-zero blanking.
module bcd_display_driver
  import bcd_pkg::*;
#(
  parameter int SCAN_DIV      = 50000,
  parameter int BLANK_LEADING = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             value_wr,
  input  logic [IN_W-1:0]  value_in,
  output logic [6:0]       seg_n,
  output logic [2:0]       dig_sel_n,
  output logic [1:0]       status
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_TC = PW'(SCAN_DIV - 1);

  state_t           state_r;
  logic [IN_W-1:0]  shift_r;
  logic [ACC_W-1:0] acc_r;
  logic [ACC_W-1:0] acc_adj_s;
  logic [3:0]       iter_r;
  logic             busy_r;
  logic             ovf_r;
  logic [3:0]       dig0_r, dig1_r, dig2_r;
  logic [3:0]       dig0_nxt_s, dig1_nxt_s, dig2_nxt_s;
  logic             ovf_nxt_s;
  logic [PW-1:0]    pre_r, pre_nxt_s;
  logic [1:0]       idx_r, idx_nxt_s;
  logic [3:0]       nib_s;
  logic             blank_s, blank1_s, blank2_s;
  logic [6:0]       seg_s;
  logic [2:0]       sel_s;
  logic [6:0]       seg_n_r;
  logic [2:0]       dig_sel_n_r;

  // Nibble correction applied to the accumulator each SHIFT cycle
  always_comb begin
    acc_adj_s = dd_adjust(acc_r);
  end

  // Conversion FSM: load, 12 dabble steps, one latch cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      shift_r <= '0;
      acc_r   <= '0;
      iter_r  <= 4'd0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (value_wr) begin
            shift_r <= value_in;
            acc_r   <= '0;
            iter_r  <= 4'd0;
            busy_r  <= 1'b1;
            state_r <= ST_SHIFT;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          {acc_r, shift_r} <= {acc_adj_s, shift_r} << 5'd1;
          iter_r <= iter_r + 4'd1;
          if (iter_r == 4'(NUM_ITER - 1)) begin
            state_r <= ST_LATCH;
          end else begin
            state_r <= ST_SHIFT;
          end
        end
        ST_LATCH: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Next display contents; the thousands nibble being non-zero means > 999
  always_comb begin
    dig0_nxt_s = dig0_r;
    dig1_nxt_s = dig1_r;
    dig2_nxt_s = dig2_r;
    ovf_nxt_s  = ovf_r;
    if (state_r == ST_LATCH) begin
      dig0_nxt_s = acc_r[3:0];
      dig1_nxt_s = acc_r[7:4];
      dig2_nxt_s = acc_r[11:8];
      ovf_nxt_s  = (acc_r[15:12] != 4'd0);
    end else begin
      ovf_nxt_s  = ovf_r;
    end
  end

  // Next scan prescaler and digit index
  always_comb begin
    pre_nxt_s = pre_r + PW'(1);
    idx_nxt_s = idx_r;
    if (pre_r == PRE_TC) begin
      pre_nxt_s = '0;
      if (idx_r == 2'(NUM_DIGITS - 1)) begin
        idx_nxt_s = 2'd0;
      end else begin
        idx_nxt_s = idx_r + 2'd1;
      end
    end else begin
      idx_nxt_s = idx_r;
    end
  end

  // Digit selection and blanking computed from next-state values so the
  // registered outputs match the registers in the same cycle
  always_comb begin
    blank2_s = (BLANK_LEADING != 0) && !ovf_nxt_s && (dig2_nxt_s == 4'd0);
    blank1_s = blank2_s && (dig1_nxt_s == 4'd0);
    nib_s    = dig0_nxt_s;
    blank_s  = 1'b0;
    sel_s    = 3'b110;
    case (idx_nxt_s)
      2'd0: begin
        nib_s   = dig0_nxt_s;
        blank_s = 1'b0;
        sel_s   = 3'b110;
      end
      2'd1: begin
        nib_s   = dig1_nxt_s;
        blank_s = blank1_s;
        sel_s   = 3'b101;
      end
      2'd2: begin
        nib_s   = dig2_nxt_s;
        blank_s = blank2_s;
        sel_s   = 3'b011;
      end
      default: begin
        nib_s   = dig0_nxt_s;
        blank_s = 1'b0;
        sel_s   = 3'b110;
      end
    endcase
  end

  bcd_seg_decoder u_seg_decoder (
    .nibble (nib_s),
    .blank  (blank_s),
    .dash   (ovf_nxt_s),
    .seg_n  (seg_s)
  );

  // Display, scan and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      dig0_r      <= 4'd0;
      dig1_r      <= 4'd0;
      dig2_r      <= 4'd0;
      ovf_r       <= 1'b0;
      pre_r       <= '0;
      idx_r       <= 2'd0;
      seg_n_r     <= SEG_0;
      dig_sel_n_r <= 3'b110;
    end else begin
      dig0_r      <= dig0_nxt_s;
      dig1_r      <= dig1_nxt_s;
      dig2_r      <= dig2_nxt_s;
      ovf_r       <= ovf_nxt_s;
      pre_r       <= pre_nxt_s;
      idx_r       <= idx_nxt_s;
      seg_n_r     <= seg_s;
      dig_sel_n_r <= sel_s;
    end
  end

  assign seg_n     = seg_n_r;
  assign dig_sel_n = dig_sel_n_r;
  assign status    = {ovf_r, busy_r};

endmodule

// File: tb/tb_bcd_display_driver.sv
// Self-checking bench: directed and random writes against a decimal-arithmetic
// reference model, on two instances (leading-zero blanking on and off).
module tb_bcd_display_driver;

  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        value_wr = 1'b0;
  logic [11:0] value_in = 12'd0;
  logic [6:0]  seg_a, seg_b;
  logic [2:0]  sel_a, sel_b;
  logic [1:0]  st_a, st_b;

  bcd_display_driver #(.SCAN_DIV(SD), .BLANK_LEADING(1)) dut (
    .clk(clk), .reset(reset), .value_wr(value_wr), .value_in(value_in),
    .seg_n(seg_a), .dig_sel_n(sel_a), .status(st_a)
  );

  bcd_display_driver #(.SCAN_DIV(SD), .BLANK_LEADING(0)) dut_nb (
    .clk(clk), .reset(reset), .value_wr(value_wr), .value_in(value_in),
    .seg_n(seg_b), .dig_sel_n(sel_b), .status(st_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [6:0] seg_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};
  logic [2:0] sel_tbl [3] = '{3'b110, 3'b101, 3'b011};

  // Reference model: a conversion takes 13 busy cycles, then shows the value
  int rem = 0;
  int pend = 0;
  int disp = 0;
  bit ovf = 1'b0;
  int scan_t = 0;

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] exp_seg(input int slot, input bit bl);
    int d2, d1, d0;
    d0 = disp % 10;
    d1 = (disp / 10) % 10;
    d2 = (disp / 100) % 10;
    if (ovf) return 7'b0111111;
    if (slot == 2) return (bl && d2 == 0) ? 7'b1111111 : seg_tbl[d2];
    if (slot == 1) return (bl && d2 == 0 && d1 == 0) ? 7'b1111111 : seg_tbl[d1];
    return seg_tbl[d0];
  endfunction

  task automatic check_all();
    int slot;
    slot = (scan_t / SD) % 3;
    chk("status_bl1", {5'd0, st_a}, {5'd0, ovf, (rem > 0)});
    chk("status_bl0", {5'd0, st_b}, {5'd0, ovf, (rem > 0)});
    chk("dig_sel_bl1", {4'd0, sel_a}, {4'd0, sel_tbl[slot]});
    chk("dig_sel_bl0", {4'd0, sel_b}, {4'd0, sel_tbl[slot]});
    chk("seg_bl1", seg_a, exp_seg(slot, 1'b1));
    chk("seg_bl0", seg_b, exp_seg(slot, 1'b0));
  endtask

  // One clock: advance the model with the inputs the DUT just sampled, then compare
  task automatic step();
    @(posedge clk);
    #1;
    if (reset) begin
      rem = 0; disp = 0; ovf = 1'b0; scan_t = 0;
    end else begin
      scan_t++;
      if (rem > 0) begin
        rem--;
        if (rem == 0) begin
          disp = pend % 1000;
          ovf = (pend > 999);
        end
      end else if (value_wr) begin
        rem = 13;
        pend = int'(value_in);
      end
    end
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic write(input int v);
    value_wr = 1'b1;
    value_in = 12'(v);
    step();
    value_wr = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    steps(2);
    reset = 1'b0;
    chk("reset_sel", {4'd0, sel_a}, 7'b0000110);
    chk("reset_seg", seg_a, 7'b1000000);
    chk("reset_status", {5'd0, st_a}, 7'd0);
    steps(3);

    // 123: busy right after the write, full scan of all three digits
    write(123);
    chk("busy_after_wr", {5'd0, st_a}, 7'd1);
    steps(12);
    chk("busy_last", {5'd0, st_a}, 7'd1);
    step();
    chk("done_status", {5'd0, st_a}, 7'd0);
    steps(14);

    // 7: leading-zero blanking on one instance, zeros on the other
    write(7);
    steps(26);

    // 1000 then 999: overflow dashes, then cleared
    write(1000);
    steps(13);
    chk("ovf_status", {5'd0, st_a}, 7'd2);
    steps(12);
    write(999);
    steps(26);

    // Writes during a conversion and in the latch cycle are ignored
    write(45);
    steps(4);
    write(999);
    steps(7);
    write(999);
    write(999);
    steps(26);

    // Reset mid-conversion aborts it
    write(500);
    steps(5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_status", {5'd0, st_a}, 7'd0);
    chk("abort_sel", {4'd0, sel_a}, 7'b0000110);
    chk("abort_seg", seg_a, 7'b1000000);
    write(321);
    steps(26);

    // Boundaries then random traffic with occasional writes while busy
    write(0);    steps(20);
    write(4095); steps(20);
    write(100);  steps(20);
    write(10);   steps(20);
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 1) == 0) write(int'($urandom_range(0, 1200)));
      else write(int'($urandom_range(0, 4095)));
      steps(int'($urandom_range(0, 20)));
    end
    steps(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
